mudi_iter: RTL and testbench
============================

Name: mudi_iter

Overview:
- Parametrised successor to the multiply/divide unit of the 5-stage MIPS core; sits in the E stage beside the ALU.
- Generalises operand width and multiply latency.
- Adds a true iterative restoring divider, a divide-by-zero flag and a commit pulse.
- Exposes start/busy/HI/LO to the hazard unit exactly as the current unit does; the interrupt request only suppresses a start.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; must be ≥ 4.
- MUL_LAT, 5, busy cycles for MULT/MULTU; must be ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  operation valid this cycle, sampled at the rising edge.
- op  in  3  operation code (package constants).
- req  in  1  exception/interrupt request; when high, start is ignored.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- busy  out  1  registered; high while an operation is in flight.
- done  out  1  one-cycle pulse in the cycle HI/LO show a new mult/div result.
- dz  out  1  one-cycle pulse when a division by zero is accepted.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, async): state IDLE; hi=lo=0; busy=done=dz=0; internal counters and shadow registers cleared.
- A start is accepted iff start=1, req=0 and state=IDLE.
  - Start while busy is a protocol violation: the start is ignored and a simulation assertion fires.
- MTHI/MTLO accepted: the edge writes a into hi/lo. No busy, no done.
- MULT/MULTU accepted:
  - Operands are captured and the 2*WIDTH product is computed (signed or unsigned) into a shadow register.
  - busy is high for exactly MUL_LAT cycles after the accepting edge.
  - At the edge ending the last busy cycle: {hi,lo} <= product, busy falls, done=1 for the following cycle.
- DIV/DIVU accepted, b != 0:
  - Magnitudes are latched: |a|, |b| for DIV; raw values for DIVU. |MIN| = 2^(WIDTH-1) fits unsigned WIDTH bits.
  - State DIV runs WIDTH restoring iterations, 1 quotient bit per cycle, MSB first.
  - State FIX (1 cycle) applies signs: quotient negated if sign(a) != sign(b); remainder takes the sign of a; truncation toward zero.
  - Commit: lo <= quotient, hi <= remainder. Busy lasts WIDTH+1 cycles; done follows the commit.
  - DIV of MIN by -1 gives lo=MIN, hi=0.
- DIV/DIVU accepted, b == 0: busy for 1 cycle; hi/lo unchanged; dz pulses with the busy cycle; no done.
- State machine:
  - IDLE -> MUL (mult) / DIV (div, b!=0) / ZERO (b==0).
  - MUL -> IDLE when the counter reaches 0.
  - DIV -> FIX after WIDTH iterations.
  - FIX -> IDLE.
  - ZERO -> IDLE.
- req during busy has no effect: the in-flight instruction has already left E and must complete. req only masks start.
- Undefined op codes with start are ignored: no state change.
- Outputs hi/lo are always the architectural registers. Intermediate values never appear on hi/lo.

Decomposition:
- Shared package (mudi_pkg):
  - op constants: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - state enum: IDLE, MUL, DIV, FIX, ZERO.
- Sub-module div_iter_core:
  - WIDTH-parametrised restoring step datapath: remainder/quotient shift register plus subtractor.
  - Controlled by the FSM in mudi_iter; iteration counter width is clog2(WIDTH+1).

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7, WIDTH=32, MUL_LAT=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV a=-7, b=2 -> 33 busy cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- DIVU a=100, b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy 1 cycle; dz pulse; hi=0x11, lo=0x22; no done.
- start=1 with req=1 (MULT 2*3) -> busy stays 0, hi/lo unchanged. Then req=1 mid-DIV 9/4 -> division completes: lo=2, hi=1.
- Assert rst=0 in cycle 10 of a DIV -> busy, hi and lo go to 0 immediately (async). After release, MTLO a=5 -> lo=5 the next cycle. Repeat with WIDTH=8, MUL_LAT=1: MULT 0x80*0x80 -> hi=0x40, lo=0x00 after 1 busy cycle.

Source files
------------

// File: rtl/mudi_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op codes and FSM states used by the unit and its bench.
package mudi_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
   localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
   localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
   localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
   localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
   localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      MUL,
      DIV,
      FIX,
      ZERO
   } state_e;

endpackage

// File: rtl/mudi_iter_if.sv
// E-stage request/response bundle between the pipeline and mudi_iter.
// master drives operands; slave returns busy/done/dz and HI/LO.
interface mudi_iter_if
   import mudi_pkg::*;
#(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic [OP_W-1:0]  op;
   logic             req;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             dz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, req, a, b,
      input  busy, done, dz, hi, lo
   );

   modport slave (
      input  start, op, req, a, b,
      output busy, done, dz, hi, lo
   );

endinterface

// File: rtl/div_iter_core.sv
// Restoring divider datapath: one unsigned quotient bit per step, MSB first.
// Sequencing comes from the owning FSM via load_i/step_i.
module div_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quo_o,
   output logic [WIDTH-1:0] rem_o,
   output logic             last_o
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH:0]   shf;
   logic [WIDTH+1:0] sub;

   // Extra top bit on the difference is the borrow (restore) flag.
   assign shf = {rem_q, quo_q[WIDTH-1]};
   assign sub = {1'b0, shf} - {2'b00, dvs_q};

   always_comb begin
      rem_d = rem_q;
      quo_d = quo_q;
      dvs_d = dvs_q;
      cnt_d = cnt_q;
      if (load_i) begin
         rem_d = '0;
         quo_d = dividend_i;
         dvs_d = divisor_i;
         cnt_d = CW'(WIDTH);
      end else if (step_i) begin
         cnt_d = cnt_q - 1'b1;
         if (sub[WIDTH+1]) begin
            rem_d = shf[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end else begin
            rem_d = sub[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
      end
   end

   assign quo_o  = quo_q;
   assign rem_o  = rem_q;
   assign last_o = (cnt_q == CW'(1));

endmodule

// File: rtl/mudi_iter.sv
// E-stage multiply/divide unit: fixed-latency multiply, iterative divide.
// HI/LO only ever change on a commit or an MTHI/MTLO.
module mudi_iter
   import mudi_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5
) (
   input  logic        clk,
   input  logic        rst,
   mudi_iter_if.slave  bus
);

   localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   state_e             state_q, state_d;
   logic [MCW-1:0]     mcnt_q, mcnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               qneg_q, qneg_d;
   logic               rneg_q, rneg_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               accept;
   logic               is_mul, is_div, b_zero;
   logic               smul, sdiv;
   logic [2*WIDTH-1:0] mul_a, mul_b;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic               load, step, last;
   logic [WIDTH-1:0]   quo, rem;

   assign accept = bus.start && !bus.req && (state_q == IDLE);
   assign is_mul = (bus.op == MD_MULT) || (bus.op == MD_MULTU);
   assign is_div = (bus.op == MD_DIV) || (bus.op == MD_DIVU);
   assign b_zero = (bus.b == '0);
   assign smul   = (bus.op == MD_MULT);
   assign sdiv   = (bus.op == MD_DIV);

   // Sign-extend only for the signed multiply; low 2W bits are exact.
   assign mul_a = {{WIDTH{smul & bus.a[WIDTH-1]}}, bus.a};
   assign mul_b = {{WIDTH{smul & bus.b[WIDTH-1]}}, bus.b};

   assign abs_a = (sdiv && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign abs_b = (sdiv && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   div_iter_core #(
      .WIDTH(WIDTH)
   ) u_div (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .step_i    (step),
      .dividend_i(abs_a),
      .divisor_i (abs_b),
      .quo_o     (quo),
      .rem_o     (rem),
      .last_o    (last)
   );

   always_comb begin
      state_d = state_q;
      mcnt_d  = mcnt_q;
      prod_d  = prod_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      done_d  = 1'b0;
      dz_d    = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               unique case (1'b1)
                  is_mul: begin
                     prod_d  = mul_a * mul_b;
                     mcnt_d  = MCW'(MUL_LAT - 1);
                     state_d = MUL;
                  end
                  (is_div && b_zero): begin
                     dz_d    = 1'b1;
                     state_d = ZERO;
                  end
                  (is_div && !b_zero): begin
                     load    = 1'b1;
                     qneg_d  = sdiv & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                     rneg_d  = sdiv & bus.a[WIDTH-1];
                     state_d = DIV;
                  end
                  (bus.op == MD_MTHI): hi_d = bus.a;
                  (bus.op == MD_MTLO): lo_d = bus.a;
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (mcnt_q == '0) begin
               {hi_d, lo_d} = prod_q;
               done_d       = 1'b1;
               state_d      = IDLE;
            end else begin
               mcnt_d = mcnt_q - 1'b1;
            end
         end
         DIV: begin
            step = 1'b1;
            if (last) state_d = FIX;
         end
         FIX: begin
            lo_d    = qneg_q ? -quo : quo;
            hi_d    = rneg_q ? -rem : rem;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         ZERO:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy_d = (state_d != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         mcnt_q  <= '0;
         prod_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mcnt_q  <= mcnt_d;
         prod_q  <= prod_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.dz   = dz_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   // The hazard unit must hold issue while busy.
   a_no_start_busy: assert property (
      @(posedge clk) disable iff (!rst)
      !(bus.start && (state_q != IDLE))
   );

endmodule

// File: tb/tb_mudi_iter.sv
// Directed bench for mudi_iter: 32-bit/5-cycle and 8-bit/1-cycle builds.
// Each task drives one scenario and checks hand-computed results.
module tb_mudi_iter;
   import mudi_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   int   cyc, nd, ndz;

   mudi_iter_if #(.WIDTH(32)) b32 ();
   mudi_iter_if #(.WIDTH(8))  b8  ();

   mudi_iter #(.WIDTH(32), .MUL_LAT(5)) u32 (
      .clk(clk),
      .rst(rst),
      .bus(b32)
   );

   mudi_iter #(.WIDTH(8), .MUL_LAT(1)) u8 (
      .clk(clk),
      .rst(rst),
      .bus(b8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic op32(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
      b32.op = o;
      b32.a = x;
      b32.b = y;
      b32.start = 1'b1;
      tick();
      b32.start = 1'b0;
      cyc = 0;
      nd = 0;
      ndz = 0;
      while (b32.busy && cyc < 200) begin
         cyc++;
         nd += int'(b32.done);
         ndz += int'(b32.dz);
         tick();
      end
      nd += int'(b32.done);
      ndz += int'(b32.dz);
   endtask

   task automatic op8(input logic [2:0] o, input logic [7:0] x,
                      input logic [7:0] y);
      b8.op = o;
      b8.a = x;
      b8.b = y;
      b8.start = 1'b1;
      tick();
      b8.start = 1'b0;
      cyc = 0;
      nd = 0;
      while (b8.busy && cyc < 200) begin
         cyc++;
         nd += int'(b8.done);
         tick();
      end
      nd += int'(b8.done);
   endtask

   task automatic test_reset;
      n_cmp += 5;
      if (b32.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", b32.busy); end
      if (b32.done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", b32.done); end
      if (b32.dz !== 1'b0) begin n_bad++; $display("FAIL rst_dz: got %b want 0", b32.dz); end
      if (b32.hi !== 32'h0) begin n_bad++; $display("FAIL rst_hi: got %h want 0", b32.hi); end
      if (b32.lo !== 32'h0) begin n_bad++; $display("FAIL rst_lo: got %h want 0", b32.lo); end
   endtask

   task automatic test_mult;
      op32(MD_MULT, 32'hFFFF_FFFD, 32'd7);
      n_cmp += 4;
      if (cyc !== 5) begin n_bad++; $display("FAIL mult_busy: got %0d want 5", cyc); end
      if (nd !== 1) begin n_bad++; $display("FAIL mult_done: got %0d want 1", nd); end
      if (b32.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want ffffffff", b32.hi); end
      if (b32.lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_lo: got %h want ffffffeb", b32.lo); end
      tick();
      n_cmp++;
      if (b32.done !== 1'b0) begin n_bad++; $display("FAIL mult_pulse: got %b want 0", b32.done); end
   endtask

   task automatic test_multu;
      op32(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n_cmp += 3;
      if (cyc !== 5) begin n_bad++; $display("FAIL multu_busy: got %0d want 5", cyc); end
      if (b32.hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi: got %h want fffffffe", b32.hi); end
      if (b32.lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo: got %h want 00000001", b32.lo); end
      tick();
   endtask

   task automatic test_div;
      op32(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      n_cmp += 4;
      if (cyc !== 33) begin n_bad++; $display("FAIL div_busy: got %0d want 33", cyc); end
      if (nd !== 1) begin n_bad++; $display("FAIL div_done: got %0d want 1", nd); end
      if (b32.lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want fffffffd", b32.lo); end
      if (b32.hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want ffffffff", b32.hi); end
      tick();
      op32(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      n_cmp += 2;
      if (b32.lo !== 32'h8000_0000) begin n_bad++; $display("FAIL divmin_lo: got %h want 80000000", b32.lo); end
      if (b32.hi !== 32'h0) begin n_bad++; $display("FAIL divmin_hi: got %h want 0", b32.hi); end
      tick();
      op32(MD_DIV, 32'd7, 32'hFFFF_FFFE);
      n_cmp += 2;
      if (b32.lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL divneg_lo: got %h want fffffffd", b32.lo); end
      if (b32.hi !== 32'h1) begin n_bad++; $display("FAIL divneg_hi: got %h want 1", b32.hi); end
      tick();
      op32(MD_DIVU, 32'hFFFF_FFFF, 32'h10);
      n_cmp += 2;
      if (b32.lo !== 32'h0FFF_FFFF) begin n_bad++; $display("FAIL divu_lo: got %h want 0fffffff", b32.lo); end
      if (b32.hi !== 32'hF) begin n_bad++; $display("FAIL divu_hi: got %h want f", b32.hi); end
      tick();
   endtask

   task automatic test_div_zero;
      op32(MD_MTHI, 32'h11, 32'h0);
      n_cmp++;
      if (cyc !== 0) begin n_bad++; $display("FAIL mthi_busy: got %0d want 0", cyc); end
      op32(MD_MTLO, 32'h22, 32'h0);
      n_cmp += 2;
      if (b32.hi !== 32'h11) begin n_bad++; $display("FAIL mthi_hi: got %h want 11", b32.hi); end
      if (b32.lo !== 32'h22) begin n_bad++; $display("FAIL mtlo_lo: got %h want 22", b32.lo); end
      op32(MD_DIVU, 32'd100, 32'd0);
      n_cmp += 5;
      if (cyc !== 1) begin n_bad++; $display("FAIL dz_busy: got %0d want 1", cyc); end
      if (ndz !== 1) begin n_bad++; $display("FAIL dz_pulse: got %0d want 1", ndz); end
      if (nd !== 0) begin n_bad++; $display("FAIL dz_done: got %0d want 0", nd); end
      if (b32.hi !== 32'h11) begin n_bad++; $display("FAIL dz_hi: got %h want 11", b32.hi); end
      if (b32.lo !== 32'h22) begin n_bad++; $display("FAIL dz_lo: got %h want 22", b32.lo); end
   endtask

   task automatic test_req;
      b32.req = 1'b1;
      b32.op = MD_MULT;
      b32.a = 32'd2;
      b32.b = 32'd3;
      b32.start = 1'b1;
      tick();
      b32.start = 1'b0;
      b32.req = 1'b0;
      n_cmp += 3;
      if (b32.busy !== 1'b0) begin n_bad++; $display("FAIL req_busy: got %b want 0", b32.busy); end
      if (b32.hi !== 32'h11) begin n_bad++; $display("FAIL req_hi: got %h want 11", b32.hi); end
      if (b32.lo !== 32'h22) begin n_bad++; $display("FAIL req_lo: got %h want 22", b32.lo); end
      b32.op = MD_DIV;
      b32.a = 32'd9;
      b32.b = 32'd4;
      b32.start = 1'b1;
      tick();
      b32.start = 1'b0;
      cyc = 0;
      while (b32.busy && cyc < 200) begin
         cyc++;
         b32.req = (cyc >= 5 && cyc < 12);
         tick();
      end
      b32.req = 1'b0;
      n_cmp += 3;
      if (cyc !== 33) begin n_bad++; $display("FAIL reqdiv_busy: got %0d want 33", cyc); end
      if (b32.lo !== 32'd2) begin n_bad++; $display("FAIL reqdiv_lo: got %h want 2", b32.lo); end
      if (b32.hi !== 32'd1) begin n_bad++; $display("FAIL reqdiv_hi: got %h want 1", b32.hi); end
      tick();
   endtask

   task automatic test_undefined;
      b32.op = 3'd7;
      b32.a = 32'hDEAD;
      b32.b = 32'h0;
      b32.start = 1'b1;
      tick();
      b32.start = 1'b0;
      n_cmp += 3;
      if (b32.busy !== 1'b0) begin n_bad++; $display("FAIL undef_busy: got %b want 0", b32.busy); end
      if (b32.hi !== 32'd1) begin n_bad++; $display("FAIL undef_hi: got %h want 1", b32.hi); end
      if (b32.lo !== 32'd2) begin n_bad++; $display("FAIL undef_lo: got %h want 2", b32.lo); end
   endtask

   task automatic test_reset_mid;
      b32.op = MD_DIVU;
      b32.a = 32'd100;
      b32.b = 32'd7;
      b32.start = 1'b1;
      tick();
      b32.start = 1'b0;
      repeat (9) tick();
      n_cmp++;
      if (b32.busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre: got %b want 1", b32.busy); end
      #2;
      rst = 1'b0;
      #1;
      n_cmp += 3;
      if (b32.busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", b32.busy); end
      if (b32.hi !== 32'h0) begin n_bad++; $display("FAIL mid_hi: got %h want 0", b32.hi); end
      if (b32.lo !== 32'h0) begin n_bad++; $display("FAIL mid_lo: got %h want 0", b32.lo); end
      #1;
      rst = 1'b1;
      tick();
      op32(MD_MTLO, 32'd5, 32'd0);
      n_cmp += 2;
      if (b32.lo !== 32'd5) begin n_bad++; $display("FAIL post_lo: got %h want 5", b32.lo); end
      if (b32.hi !== 32'd0) begin n_bad++; $display("FAIL post_hi: got %h want 0", b32.hi); end
   endtask

   task automatic test_w8;
      op8(MD_MULT, 8'h80, 8'h80);
      n_cmp += 4;
      if (cyc !== 1) begin n_bad++; $display("FAIL w8_busy: got %0d want 1", cyc); end
      if (nd !== 1) begin n_bad++; $display("FAIL w8_done: got %0d want 1", nd); end
      if (b8.hi !== 8'h40) begin n_bad++; $display("FAIL w8_hi: got %h want 40", b8.hi); end
      if (b8.lo !== 8'h00) begin n_bad++; $display("FAIL w8_lo: got %h want 00", b8.lo); end
      tick();
      op8(MD_DIV, 8'h80, 8'hFF);
      n_cmp += 3;
      if (cyc !== 9) begin n_bad++; $display("FAIL w8div_busy: got %0d want 9", cyc); end
      if (b8.lo !== 8'h80) begin n_bad++; $display("FAIL w8div_lo: got %h want 80", b8.lo); end
      if (b8.hi !== 8'h00) begin n_bad++; $display("FAIL w8div_hi: got %h want 00", b8.hi); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b0;
      b32.start = 1'b0;
      b32.op = '0;
      b32.req = 1'b0;
      b32.a = '0;
      b32.b = '0;
      b8.start = 1'b0;
      b8.op = '0;
      b8.req = 1'b0;
      b8.a = '0;
      b8.b = '0;
      #12;
      test_reset();
      rst = 1'b1;
      tick();
      test_mult();
      test_multu();
      test_div();
      test_div_zero();
      test_req();
      test_undefined();
      test_reset_mid();
      test_w8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
